// File: rtl/tm1638_frame_writer.sv
// tm1638_frame_writer: turns six BCD clock digits into a complete TM1638
// refresh (data-write command, address + 16 display bytes, display-on
// command) and bit-bangs it out on stb/sclk/dio. Write-only, LSB first.
module tm1638_frame_writer #(
   parameter int unsigned CLK_DIV    = 25,
   parameter logic [2:0]  BRIGHTNESS = 3'd7
) (
   input  logic       clk_50M,
   input  logic       RST,
   input  logic       start,
   input  logic [3:0] hour_tens,
   input  logic [3:0] hour_digits,
   input  logic [3:0] min_tens,
   input  logic [3:0] min_digits,
   input  logic [3:0] sec_tens,
   input  logic [3:0] sec_digits,
   output logic       busy,
   output logic       done,
   output logic       stb,
   output logic       sclk,
   output logic       dio,
   output logic [7:0] data_check
);

   // Divider must reach 2*CLK_DIV-1 for the inter-frame gap.
   localparam int unsigned   DivW     = $clog2(2 * CLK_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [DivW-1:0] GapLast = DivW'(2 * CLK_DIV - 1);
   localparam logic [7:0]    CmdWrite = 8'h40;
   localparam logic [7:0]    CmdAddr0 = 8'hC0;
   localparam logic [7:0]    CmdDisp  = 8'h88 | {5'b00000, BRIGHTNESS};
   localparam logic [7:0]    SegDash  = 8'h40;

   typedef enum logic [2:0] {
      StIdle,
      StStbSetup,
      StBitLow,
      StBitHigh,
      StStbHold,
      StGap
   } state_e;

   state_e          r_state, w_state_nxt;
   logic [DivW-1:0] r_div,   w_div_nxt;
   logic [2:0]      r_bit,   w_bit_nxt;
   logic [4:0]      r_byte,  w_byte_nxt;
   logic [1:0]      r_frame, w_frame_nxt;
   logic [7:0]      r_tx,    w_tx_nxt;
   logic [7:0]      r_check, w_check_nxt;
   logic            r_done,  w_done_nxt;
   logic [23:0]     r_dig,   w_dig_nxt;

   logic            w_div_end;
   logic [4:0]      w_ld_idx;
   logic [4:0]      w_last_idx;
   logic [3:0]      w_addr;
   logic [7:0]      w_slot;
   logic [7:0]      w_ld_byte;

   // Common-cathode gfedcba encoding; non-BCD codes blank the digit.
   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'h3F;
         4'd1:    seg7 = 8'h06;
         4'd2:    seg7 = 8'h5B;
         4'd3:    seg7 = 8'h4F;
         4'd4:    seg7 = 8'h66;
         4'd5:    seg7 = 8'h6D;
         4'd6:    seg7 = 8'h7D;
         4'd7:    seg7 = 8'h07;
         4'd8:    seg7 = 8'h7F;
         4'd9:    seg7 = 8'h6F;
         default: seg7 = 8'h00;
      endcase
   endfunction

   assign w_div_end  = (r_div == DivLast);
   // Index of the byte about to be loaded: 0 at frame start, else the next one.
   assign w_ld_idx   = (r_state == StStbSetup) ? 5'd0 : (r_byte + 5'd1);
   assign w_last_idx = (r_frame == 2'd1) ? 5'd16 : 5'd0;
   // F2 byte n (n>=1) carries display address n-1.
   assign w_addr     = w_ld_idx[3:0] - 4'd1;

   // Byte lookup for the current frame and load index.
   always_comb begin
      w_slot    = 8'h00;
      w_ld_byte = 8'h00;
      case (w_addr[3:1])
         3'd0:    w_slot = seg7(r_dig[23:20]);
         3'd1:    w_slot = seg7(r_dig[19:16]);
         3'd2:    w_slot = SegDash;
         3'd3:    w_slot = seg7(r_dig[15:12]);
         3'd4:    w_slot = seg7(r_dig[11:8]);
         3'd5:    w_slot = SegDash;
         3'd6:    w_slot = seg7(r_dig[7:4]);
         default: w_slot = seg7(r_dig[3:0]);
      endcase
      if (r_frame == 2'd0) begin
         w_ld_byte = CmdWrite;
      end else if (r_frame == 2'd1) begin
         if (w_ld_idx == 5'd0) begin
            w_ld_byte = CmdAddr0;
         end else if (!w_addr[0]) begin
            w_ld_byte = w_slot;
         end
      end else begin
         w_ld_byte = CmdDisp;
      end
   end

   // Next-state logic for the serial sequencer.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_byte_nxt  = r_byte;
      w_frame_nxt = r_frame;
      w_tx_nxt    = r_tx;
      w_check_nxt = r_check;
      w_done_nxt  = 1'b0;
      w_dig_nxt   = r_dig;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_state_nxt = StStbSetup;
               w_div_nxt   = '0;
               w_bit_nxt   = 3'd0;
               w_byte_nxt  = 5'd0;
               w_frame_nxt = 2'd0;
               w_dig_nxt   = {hour_tens, hour_digits, min_tens, min_digits,
                              sec_tens, sec_digits};
            end
         end
         StStbSetup: begin
            if (w_div_end) begin
               w_state_nxt = StBitLow;
               w_div_nxt   = '0;
               w_bit_nxt   = 3'd0;
               w_byte_nxt  = 5'd0;
               w_tx_nxt    = w_ld_byte;
               w_check_nxt = w_ld_byte;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         StBitLow: begin
            if (w_div_end) begin
               w_state_nxt = StBitHigh;
               w_div_nxt   = '0;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         StBitHigh: begin
            if (w_div_end) begin
               w_div_nxt = '0;
               if (r_bit != 3'd7) begin
                  w_state_nxt = StBitLow;
                  w_bit_nxt   = r_bit + 3'd1;
               end else if (r_byte != w_last_idx) begin
                  // Bytes within a frame run back-to-back.
                  w_state_nxt = StBitLow;
                  w_bit_nxt   = 3'd0;
                  w_byte_nxt  = r_byte + 5'd1;
                  w_tx_nxt    = w_ld_byte;
                  w_check_nxt = w_ld_byte;
               end else begin
                  w_state_nxt = StStbHold;
               end
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         StStbHold: begin
            if (w_div_end) begin
               w_div_nxt = '0;
               if (r_frame == 2'd2) begin
                  w_state_nxt = StIdle;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = StGap;
               end
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         StGap: begin
            if (r_div == GapLast) begin
               w_state_nxt = StStbSetup;
               w_div_nxt   = '0;
               w_frame_nxt = r_frame + 2'd1;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State register and datapath flops; reset aborts any transfer at once.
   always_ff @(posedge clk_50M or negedge RST) begin
      if (!RST) begin
         r_state <= StIdle;
         r_div   <= '0;
         r_bit   <= 3'd0;
         r_byte  <= 5'd0;
         r_frame <= 2'd0;
         r_tx    <= 8'h00;
         r_check <= 8'h00;
         r_done  <= 1'b0;
         r_dig   <= 24'h000000;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_byte  <= w_byte_nxt;
         r_frame <= w_frame_nxt;
         r_tx    <= w_tx_nxt;
         r_check <= w_check_nxt;
         r_done  <= w_done_nxt;
         r_dig   <= w_dig_nxt;
      end
   end

   // Pin decode straight from state so reset forces idle levels immediately.
   assign busy       = (r_state != StIdle);
   assign done       = r_done;
   assign stb        = (r_state == StIdle) || (r_state == StGap);
   assign sclk       = (r_state != StBitLow);
   assign dio        = ((r_state == StBitLow) || (r_state == StBitHigh)) ? r_tx[r_bit] : 1'b1;
   assign data_check = r_check;

endmodule
